// File: rtl/sine_cmd_sched_if.sv
// sine_cmd_sched_if: UART byte stream, phase address and command outputs
// of the sine-generator command scheduler.
interface sine_cmd_sched_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [9:0]  addr_active;
  logic [2:0]  mode;
  logic [15:0] factor;
  logic        factor_load;
  logic        pending;
  logic        err;

  modport master (
    output rx_valid, rx_byte, addr_active,
    input  mode, factor, factor_load, pending, err
  );

  modport slave (
    input  rx_valid, rx_byte, addr_active,
    output mode, factor, factor_load, pending, err
  );
endinterface

// File: rtl/sine_cmd_sched.sv
// sine_cmd_sched: framed UART command parser with phase-wrap commit.
// Define CMD_CHECKSUM_EN for a trailing XOR checksum byte per frame.
module sine_cmd_sched #(
  parameter int unsigned BYTE_TO    = 50000,
  parameter int unsigned SWITCH_TO  = 2000000,
  parameter logic [15:0] FACTOR_RST = 16'd1000
) (
  input logic             clk,
  input logic             rst_n,
  sine_cmd_sched_if.slave bus
);
  localparam int BW = $clog2(BYTE_TO + 1);
  localparam int SW = $clog2(SWITCH_TO + 1);
  localparam logic [2:0] M_IDLE = 3'b000;
  localparam logic [2:0] M_TMR  = 3'b001;
  localparam logic [2:0] M_FRQ  = 3'b010;

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_CK} state_t;
  logic [7:0] lo_q, lo_d, ck_q, ck_d;
  logic       tmr_q, tmr_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sw_q, sw_d;
  logic [2:0]  mode_q, mode_d, rmode_q, rmode_d;
  logic [15:0] fac_q, fac_d, rfac_q, rfac_d;
  logic        pend_q, pend_d, load_q, load_d, err_q, err_d;
  logic        req, commit, is_t, is_f;
  logic [2:0]  nmode;
  logic [15:0] nfac;

  assign is_t = bus.rx_byte == 8'h54;
  assign is_f = bus.rx_byte == 8'h46;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    mode_d  = mode_q;
    fac_d   = fac_q;
    rmode_d = rmode_q;
    rfac_d  = rfac_q;
    pend_d  = pend_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    req     = 1'b0;
    nmode   = M_TMR;
    nfac    = rfac_q;
`ifdef CMD_CHECKSUM_EN
    lo_d  = lo_q;
    ck_d  = ck_q;
    tmr_d = tmr_q;
`endif
    // inter-byte timeout only runs mid-frame
    if (state_q != S_IDLE) begin
      if (bus.rx_valid) begin
        cnt_d = '0;
      end else if (cnt_q == BW'(BYTE_TO - 1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (bus.rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            is_t: begin
`ifdef CMD_CHECKSUM_EN
              state_d = S_CK;
              tmr_d   = 1'b1;
              ck_d    = bus.rx_byte;
`else
              req   = 1'b1;
              nmode = M_TMR;
`endif
            end
            is_f: begin
              state_d = S_HI;
`ifdef CMD_CHECKSUM_EN
              tmr_d = 1'b0;
              ck_d  = bus.rx_byte;
`endif
            end
            default: err_d = 1'b1;
          endcase
        end
        S_HI: begin
          hi_d    = bus.rx_byte;
          state_d = S_LO;
`ifdef CMD_CHECKSUM_EN
          ck_d = ck_q ^ bus.rx_byte;
`endif
        end
        S_LO: begin
`ifdef CMD_CHECKSUM_EN
          lo_d    = bus.rx_byte;
          ck_d    = ck_q ^ bus.rx_byte;
          state_d = S_CK;
`else
          req     = 1'b1;
          nmode   = M_FRQ;
          nfac    = {hi_q, bus.rx_byte};
          state_d = S_IDLE;
`endif
        end
`ifdef CMD_CHECKSUM_EN
        S_CK: begin
          state_d = S_IDLE;
          if (bus.rx_byte == ck_q) begin
            req   = 1'b1;
            nmode = tmr_q ? M_TMR : M_FRQ;
            nfac  = {hi_q, lo_q};
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    // commit uses the request held before this cycle's frame completes
    commit = pend_q && (bus.addr_active == '0 || mode_q == M_IDLE ||
                        sw_q == SW'(SWITCH_TO - 1));
    if (commit) begin
      mode_d = rmode_q;
      if (rmode_q == M_FRQ) fac_d = rfac_q;
      load_d = 1'b1;
      pend_d = 1'b0;
      sw_d   = '0;
    end else if (pend_q) begin
      sw_d = sw_q + 1'b1;
    end
    if (req) begin
      rmode_d = nmode;
      if (nmode == M_FRQ) rfac_d = nfac;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      mode_q  <= M_IDLE;
      fac_q   <= FACTOR_RST;
      rmode_q <= M_IDLE;
      rfac_q  <= FACTOR_RST;
      pend_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      lo_q  <= '0;
      ck_q  <= '0;
      tmr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      mode_q  <= mode_d;
      fac_q   <= fac_d;
      rmode_q <= rmode_d;
      rfac_q  <= rfac_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
      err_q   <= err_d;
`ifdef CMD_CHECKSUM_EN
      lo_q  <= lo_d;
      ck_q  <= ck_d;
      tmr_q <= tmr_d;
`endif
    end
  end

  assign bus.mode        = mode_q;
  assign bus.factor      = fac_q;
  assign bus.factor_load = load_q;
  assign bus.pending     = pend_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_sine_cmd_sched.sv
// tb_sine_cmd_sched: table vectors, directed corner sequences and
// randomized frames against a frame-queue reference model.
module tb_sine_cmd_sched;
  localparam int unsigned BYTE_TO   = 20;
  localparam int unsigned SWITCH_TO = 40;
  localparam logic [15:0] FRST      = 16'd1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_cmd_sched_if bus ();

  sine_cmd_sched #(
    .BYTE_TO(BYTE_TO),
    .SWITCH_TO(SWITCH_TO),
    .FACTOR_RST(FRST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic [9:0]  a;
    logic [2:0]  mode;
    logic [15:0] fac;
    logic        load;
    logic        pend;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nbad = 0;
  int ncyc = 0;
  int nload = 0;
  int nerr = 0;
  bit rnd_addr = 0;

  // reference model state
  logic [7:0]  fq[$];
  int          m_gap, m_age;
  logic [2:0]  m_mode, m_rm;
  logic [15:0] m_fac, m_rf;
  logic        m_pend, e_load, e_err;

`ifdef CMD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  function automatic vec_t V(logic v, logic [7:0] b, logic [9:0] a,
                             logic [2:0] m, logic [15:0] f,
                             logic l, logic p, logic e);
    vec_t r;
    r.v = v; r.b = b; r.a = a; r.mode = m; r.fac = f;
    r.load = l; r.pend = p; r.err = e;
    return r;
  endfunction

  task automatic model_reset();
    fq.delete();
    m_gap = 0; m_age = 0;
    m_mode = 3'd0; m_rm = 3'd0;
    m_fac = FRST; m_rf = FRST;
    m_pend = 0; e_load = 0; e_err = 0;
  endtask

  function automatic int flen(logic [7:0] h);
    if (h == 8'h54) return CK ? 2 : 1;
    return CK ? 4 : 3;
  endfunction

  task automatic mstep(logic v, logic [7:0] b, logic [9:0] a);
    bit commit, rq, ok;
    logic [2:0] rm;
    logic [15:0] rf;
    logic [7:0] x;
    commit = m_pend && (a == 10'd0 || m_mode == 3'd0 ||
                        m_age == int'(SWITCH_TO) - 1);
    rq = 0; rm = 3'd0; rf = 16'd0; e_err = 0;
    if (v) begin
      m_gap = 0;
      if (fq.size() == 0 && b != 8'h54 && b != 8'h46) begin
        e_err = 1;
      end else begin
        fq.push_back(b);
        if (fq.size() == flen(fq[0])) begin
          ok = 1;
          if (CK) begin
            x = 8'h00;
            for (int i = 0; i < fq.size() - 1; i++) x = x ^ fq[i];
            ok = (x == fq[fq.size() - 1]);
          end
          if (ok) begin
            rq = 1;
            if (fq[0] == 8'h54) rm = 3'd1;
            else begin
              rm = 3'd2;
              rf = {fq[1], fq[2]};
            end
          end else e_err = 1;
          fq.delete();
        end
      end
    end else if (fq.size() != 0) begin
      m_gap++;
      if (m_gap == int'(BYTE_TO)) begin
        e_err = 1;
        fq.delete();
        m_gap = 0;
      end
    end
    e_load = commit;
    if (commit) begin
      m_mode = m_rm;
      if (m_rm == 3'd2) m_fac = m_rf;
      m_pend = 0;
      m_age = 0;
    end else if (m_pend) m_age++;
    if (rq) begin
      m_rm = rm;
      if (rm == 3'd2) m_rf = rf;
      m_pend = 1;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(logic v, logic [7:0] b, logic [9:0] a);
    logic [9:0] ae;
    ae = a;
    if (rnd_addr)
      ae = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
    bus.rx_valid = v;
    bus.rx_byte = b;
    bus.addr_active = ae;
    mstep(v, b, ae);
    @(posedge clk);
    #1;
    ncyc++;
    if (bus.factor_load) nload++;
    if (bus.err) nerr++;
    nvec++;
    if (bus.mode !== m_mode || bus.factor !== m_fac ||
        bus.factor_load !== e_load || bus.pending !== m_pend ||
        bus.err !== e_err) begin
      nbad++;
      $display("FAIL model cyc%0d: mode %0h/%0h fac %0h/%0h load %0b/%0b pend %0b/%0b err %0b/%0b (dut/exp)",
               ncyc, bus.mode, m_mode, bus.factor, m_fac, bus.factor_load,
               e_load, bus.pending, m_pend, bus.err, e_err);
    end
  endtask

  task automatic send_t(logic [9:0] a);
    cyc(1, 8'h54, a);
    if (CK) cyc(1, 8'h54, a);
  endtask

  task automatic send_f(logic [7:0] hi, logic [7:0] lo, logic [9:0] a);
    cyc(1, 8'h46, a);
    cyc(1, hi, a);
    cyc(1, lo, a);
    if (CK) cyc(1, 8'h46 ^ hi ^ lo, a);
  endtask

  task automatic chk_reset(string name);
    chk({name, ".mode"}, int'(bus.mode), 0);
    chk({name, ".factor"}, int'(bus.factor), int'(FRST));
    chk({name, ".load"}, int'(bus.factor_load), 0);
    chk({name, ".pend"}, int'(bus.pending), 0);
    chk({name, ".err"}, int'(bus.err), 0);
  endtask

  initial begin
    int l0, e0, cnt;
    bit done;
    bus.rx_valid = 0;
    bus.rx_byte = 8'h00;
    bus.addr_active = 10'd5;
    model_reset();
    #12;
    chk_reset("reset");
    @(posedge clk);
    #1 rst_n = 1;

`ifdef CMD_CHECKSUM_EN
    tbl.push_back(V(1, 8'h46, 5, 0, FRST, 0, 0, 0));
    tbl.push_back(V(1, 8'h01, 5, 0, FRST, 0, 0, 0));
    tbl.push_back(V(1, 8'hF4, 5, 0, FRST, 0, 0, 0));
    tbl.push_back(V(1, 8'hB3, 5, 0, FRST, 0, 1, 0));
    tbl.push_back(V(0, 8'h00, 5, 2, 16'h01F4, 1, 0, 0));
    tbl.push_back(V(0, 8'h00, 5, 2, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(1, 8'h54, 5, 2, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(1, 8'h54, 5, 2, 16'h01F4, 0, 1, 0));
    tbl.push_back(V(0, 8'h00, 3, 2, 16'h01F4, 0, 1, 0));
    tbl.push_back(V(0, 8'h00, 0, 1, 16'h01F4, 1, 0, 0));
    tbl.push_back(V(1, 8'h99, 0, 1, 16'h01F4, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 1, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(1, 8'h46, 7, 1, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(1, 8'h01, 7, 1, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(1, 8'h02, 7, 1, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(1, 8'h45, 7, 1, 16'h01F4, 0, 1, 0));
    tbl.push_back(V(0, 8'h00, 0, 2, 16'h0102, 1, 0, 0));
    tbl.push_back(V(1, 8'h46, 0, 2, 16'h0102, 0, 0, 0));
    tbl.push_back(V(1, 8'h01, 0, 2, 16'h0102, 0, 0, 0));
    tbl.push_back(V(1, 8'h02, 0, 2, 16'h0102, 0, 0, 0));
    tbl.push_back(V(1, 8'h00, 0, 2, 16'h0102, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 2, 16'h0102, 0, 0, 0));
`else
    tbl.push_back(V(1, 8'h46, 5, 0, FRST, 0, 0, 0));
    tbl.push_back(V(1, 8'h01, 5, 0, FRST, 0, 0, 0));
    tbl.push_back(V(1, 8'hF4, 5, 0, FRST, 0, 1, 0));
    tbl.push_back(V(0, 8'h00, 5, 2, 16'h01F4, 1, 0, 0));
    tbl.push_back(V(0, 8'h00, 5, 2, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(1, 8'h54, 5, 2, 16'h01F4, 0, 1, 0));
    tbl.push_back(V(0, 8'h00, 3, 2, 16'h01F4, 0, 1, 0));
    tbl.push_back(V(0, 8'h00, 0, 1, 16'h01F4, 1, 0, 0));
    tbl.push_back(V(1, 8'h99, 0, 1, 16'h01F4, 0, 0, 1));
    tbl.push_back(V(0, 8'h00, 0, 1, 16'h01F4, 0, 0, 0));
    tbl.push_back(V(0, 8'h54, 0, 1, 16'h01F4, 0, 0, 0));
`endif
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].a);
      nvec++;
      if (bus.mode !== tbl[i].mode || bus.factor !== tbl[i].fac ||
          bus.factor_load !== tbl[i].load || bus.pending !== tbl[i].pend ||
          bus.err !== tbl[i].err) begin
        nbad++;
        $display("FAIL tbl[%0d]: mode %0h/%0h fac %0h/%0h load %0b/%0b pend %0b/%0b err %0b/%0b (dut/exp)",
                 i, bus.mode, tbl[i].mode, bus.factor, tbl[i].fac,
                 bus.factor_load, tbl[i].load, bus.pending, tbl[i].pend,
                 bus.err, tbl[i].err);
      end
    end

    // inter-byte timeout, then a clean frame
    cyc(1, 8'h46, 3);
    cyc(1, 8'h03, 3);
    for (int i = 1; i <= int'(BYTE_TO); i++) begin
      cyc(0, 8'h00, 3);
      chk($sformatf("timeout.err%0d", i), int'(bus.err), int'(i == int'(BYTE_TO)));
      chk("timeout.pend", int'(bus.pending), 0);
    end
    send_f(8'h00, 8'h64, 0);
    cyc(0, 8'h00, 0);
    chk("timeout.factor", int'(bus.factor), 16'h0064);

    // latest request wins
    l0 = nload;
    send_f(8'hAB, 8'hCD, 7);
    send_f(8'h12, 8'h34, 7);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    chk("latest.loads", nload - l0, 1);
    chk("latest.factor", int'(bus.factor), 16'h1234);

    // stuck address forces the commit after SWITCH_TO pending cycles
    e0 = nerr;
    send_t(9);
    cnt = int'(bus.pending);
    done = 0;
    for (int i = 0; i < int'(SWITCH_TO) + 5 && !done; i++) begin
      cyc(0, 8'h00, 9);
      if (bus.pending) cnt++;
      else done = 1;
    end
    chk("force.done", int'(done), 1);
    chk("force.cycles", cnt, int'(SWITCH_TO));
    chk("force.mode", int'(bus.mode), 1);
    chk("force.noerr", nerr - e0, 0);

    // reset in the middle of a frame
    cyc(1, 8'h46, 4);
    cyc(1, 8'h12, 4);
    #2 rst_n = 0;
    #1;
    chk_reset("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    send_t(4);
    chk("midrst.pend", int'(bus.pending), 1);
    cyc(0, 8'h00, 4);
    chk("midrst.mode", int'(bus.mode), 1);

    // randomized frames, garbage and gaps
    rnd_addr = 1;
    for (int i = 0; i < 300; i++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      if (k < 4) send_f(8'($urandom), 8'($urandom), 0);
      else if (k < 6) send_t(0);
      else if (k < 8) cyc(1, 8'($urandom), 0);
      else repeat ($urandom_range(0, 25)) cyc(0, 8'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
